seg7_scan_capture: RTL and testbench



---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_pattern_to_bcd.sv | 39 +++
 rtl/seg7_scan_capture.sv | 131 +++++++++++++
 tb/tb_seg7_scan_capture.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the 7-segment encode/decode blocks.
// Segment vectors are ordered {g,f,e,d,c,b,a}, i.e. bit0 = a ... bit6 = g,
// active-high. BCD_BLANK marks an unlit digit, BCD_ERR an unrecognised one.
package seg7_pkg;

    localparam logic [6:0] SEG7_0     = 7'b0111111;
    localparam logic [6:0] SEG7_1     = 7'b0000110;
    localparam logic [6:0] SEG7_2     = 7'b1011011;
    localparam logic [6:0] SEG7_3     = 7'b1001111;
    localparam logic [6:0] SEG7_4     = 7'b1100110;
    localparam logic [6:0] SEG7_5     = 7'b1101101;
    localparam logic [6:0] SEG7_6     = 7'b1111101;
    localparam logic [6:0] SEG7_7     = 7'b0000111;
    localparam logic [6:0] SEG7_8     = 7'b1111111;
    localparam logic [6:0] SEG7_9     = 7'b1101111;
    localparam logic [6:0] SEG7_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] BCD_ERR    = 4'hE;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// seg7_pattern_to_bcd
// Combinational map from an active-high segment pattern back to a BCD nibble.
// Only exact digit patterns are accepted; all segments off is a blank digit.
// Ports:
//   seg  in  7  segment pattern, bit0 = a ... bit6 = g
//   bcd  out 4  decoded digit, BCD_BLANK for blank, BCD_ERR for anything else
//   err  out 1  high when the pattern is neither a digit nor blank
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    // Exact-match lookup; partial or ghosted patterns fall through to error.
    always_comb begin
        bcd = BCD_ERR;
        err = 1'b0;
        case (seg)
            SEG7_0:     bcd = 4'd0;
            SEG7_1:     bcd = 4'd1;
            SEG7_2:     bcd = 4'd2;
            SEG7_3:     bcd = 4'd3;
            SEG7_4:     bcd = 4'd4;
            SEG7_5:     bcd = 4'd5;
            SEG7_6:     bcd = 4'd6;
            SEG7_7:     bcd = 4'd7;
            SEG7_8:     bcd = 4'd8;
            SEG7_9:     bcd = 4'd9;
            SEG7_BLANK: bcd = BCD_BLANK;
            default: begin
                bcd = BCD_ERR;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Watches a multiplexed 7-segment bus, waits for each digit slot to settle,
// decodes the pattern back to BCD and publishes a complete frame once every
// digit slot has been captured.
// Optional build macro: SEG7_ACTIVE_LOW_EN inverts seg and an at the input
// stage for common-anode boards; otherwise the bus is active-high.
// Ports:
//   clk          in   1             system clock, rising edge
//   rst          in   1             asynchronous active-high reset
//   seg          in   7             segment lines, bit0 = a ... bit6 = g
//   an           in   NUM_DIGITS    one-hot digit enables
//   clear        in   1             drops the partial frame and the error flag
//   digits       out  4*NUM_DIGITS  last complete frame, digit i at [4i+3:4i]
//   frame_valid  out  1             one-cycle pulse when digits updates
//   pattern_err  out  1             sticky flag for an unrecognised pattern
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    frame_valid,
    output logic                    pattern_err
);

    localparam logic [CNT_W-1:0] SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [CNT_W-1:0]        cnt;
    logic                    captured;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] shadow;

    logic                    stable;
    logic                    capture;
    logic [3:0]              nibble;
    logic                    nibble_err;
    logic [NUM_DIGITS-1:0]   mask_upd;
    logic [4*NUM_DIGITS-1:0] shadow_upd;

`ifdef SEG7_ACTIVE_LOW_EN
    assign seg_in = ~seg;
    assign an_in  = ~an;
`else
    assign seg_in = seg;
    assign an_in  = an;
`endif

    seg7_pattern_to_bcd u_decode (
        .seg (seg_q),
        .bcd (nibble),
        .err (nibble_err)
    );

    // A sample is taken once per settled slot: the bus must match its
    // registered copy, the counter must be on its last step, exactly one
    // digit enable must be lit (blanking and ghosting are skipped), and the
    // slot must not have been captured already.
    assign stable  = (seg_in == seg_q) && (an_in == an_q);
    assign capture = stable && (cnt == SETTLE_LAST) && $onehot(an_q)
                     && !captured && !clear;

    // Shadow/mask as they would look after this capture. an_q is one-hot
    // whenever the result is used, so it doubles as the slot select.
    always_comb begin
        shadow_upd = shadow;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_q[i]) begin
                shadow_upd[4*i +: 4] = nibble;
            end
        end
        mask_upd = mask | an_q;
    end

    // Input stage, settle counter and frame assembly. clear takes priority
    // over a coinciding capture, which is dropped along with its error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q       <= '0;
            an_q        <= '0;
            cnt         <= '0;
            captured    <= 1'b0;
            mask        <= '0;
            shadow      <= '0;
            digits      <= {NUM_DIGITS{BCD_BLANK}};
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            seg_q       <= seg_in;
            an_q        <= an_in;
            frame_valid <= 1'b0;

            if (!stable) begin
                cnt      <= '0;
                captured <= 1'b0;
            end else if (cnt != SETTLE_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (clear) begin
                mask        <= '0;
                pattern_err <= 1'b0;
            end else if (capture) begin
                captured <= 1'b1;
                shadow   <= shadow_upd;
                if (nibble_err) begin
                    pattern_err <= 1'b1;
                end
                if (&mask_upd) begin
                    digits      <= shadow_upd;
                    frame_valid <= 1'b1;
                    mask        <= '0;
                end else begin
                    mask <= mask_upd;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture
// Directed self-checking bench for seg7_scan_capture with 4 digits and an
// 8-cycle settle time. Each scenario task drives the bus and checks its own
// expected values; outputs are sampled 1 time unit after each rising edge.
module tb_seg7_scan_capture;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        clear;
    logic [15:0] digits;
    logic        frame_valid;
    logic        pattern_err;

    int checks;
    int errors;
    int fv_count;

    seg7_scan_capture #(
        .NUM_DIGITS    (4),
        .SETTLE_CYCLES (8),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .clear       (clear),
        .digits      (digits),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent copy of the segment table, bit0 = a ... bit6 = g
    function automatic logic [6:0] pat(input int d);
        case (d)
            0:       pat = 7'b0111111;
            1:       pat = 7'b0000110;
            2:       pat = 7'b1011011;
            3:       pat = 7'b1001111;
            4:       pat = 7'b1100110;
            5:       pat = 7'b1101101;
            6:       pat = 7'b1111101;
            7:       pat = 7'b0000111;
            8:       pat = 7'b1111111;
            9:       pat = 7'b1101111;
            default: pat = 7'b0000000;
        endcase
    endfunction

    // Drive one bus state for 'hold' edges, counting frame_valid pulses and
    // reporting the step (1 = the edge that registers the change) of the first.
    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s,
                                 input int hold, output int first_fv);
        an       = a;
        seg      = s;
        first_fv = 0;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1) begin
                fv_count++;
                if (first_fv == 0) first_fv = k;
            end
        end
    endtask

    task automatic idle(input int n);
        int dummy;
        applyStimulus(4'b0000, 7'b0000000, n, dummy);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        seg   = 7'b0;
        an    = 4'b0;
        clear = 1'b0;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (digits !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL reset_digits: got %h expected ffff", digits);
        end
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_fv: got %b expected 0", frame_valid);
        end
        checks++;
        if (pattern_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err: got %b expected 0", pattern_err);
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic_scan();
        int first;
        fv_count = 0;
        applyStimulus(4'b0001, pat(1), 16, first);
        applyStimulus(4'b0010, pat(2), 16, first);
        applyStimulus(4'b0100, pat(3), 16, first);
        applyStimulus(4'b1000, pat(4), 16, first);
        checks++;
        if (first !== 9) begin
            errors++;
            $display("[TB] FAIL basic_latency: got step %0d expected 9", first);
        end
        idle(4);
        checks++;
        if (fv_count !== 1) begin
            errors++;
            $display("[TB] FAIL basic_fv_count: got %0d expected 1", fv_count);
        end
        checks++;
        if (digits !== 16'h4321) begin
            errors++;
            $display("[TB] FAIL basic_digits: got %h expected 4321", digits);
        end
        checks++;
        if (pattern_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_err: got %b expected 0", pattern_err);
        end
    endtask

    task automatic test_short_hold();
        int first;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        fv_count = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001 << i, pat(i + 5), 5, first);
        end
        idle(4);
        checks++;
        if (fv_count !== 0) begin
            errors++;
            $display("[TB] FAIL short_fv_count: got %0d expected 0", fv_count);
        end
        checks++;
        if (digits !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL short_digits: got %h expected ffff", digits);
        end
    endtask

    task automatic test_bad_pattern();
        int first;
        fv_count = 0;
        applyStimulus(4'b0001, pat(1), 16, first);
        applyStimulus(4'b0010, pat(2), 16, first);
        applyStimulus(4'b0100, 7'b1110000, 16, first);
        applyStimulus(4'b1000, pat(4), 16, first);
        idle(4);
        checks++;
        if (digits !== 16'h4E21 || fv_count !== 1) begin
            errors++;
            $display("[TB] FAIL bad_digits: got %h (pulses %0d) expected 4e21 (pulses 1)",
                     digits, fv_count);
        end
        checks++;
        if (pattern_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_err_set: got %b expected 1", pattern_err);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001 << i, pat(i + 5), 16, first);
        end
        idle(4);
        checks++;
        if (digits !== 16'h8765) begin
            errors++;
            $display("[TB] FAIL good_after_bad_digits: got %h expected 8765", digits);
        end
        checks++;
        if (pattern_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_err_sticky: got %b expected 1", pattern_err);
        end
        pulse_clear();
        checks++;
        if (pattern_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bad_err_cleared: got %b expected 0", pattern_err);
        end
        checks++;
        if (digits !== 16'h8765) begin
            errors++;
            $display("[TB] FAIL clear_keeps_digits: got %h expected 8765", digits);
        end
    endtask

    task automatic test_ghosting();
        int first;
        fv_count = 0;
        applyStimulus(4'b0001, pat(9), 16, first);
        applyStimulus(4'b0011, pat(8), 20, first);
        applyStimulus(4'b0010, pat(0), 16, first);
        applyStimulus(4'b0000, pat(3), 20, first);
        applyStimulus(4'b0100, pat(7), 16, first);
        applyStimulus(4'b0011, 7'b1110000, 20, first);
        applyStimulus(4'b1000, pat(6), 16, first);
        idle(4);
        checks++;
        if (fv_count !== 1) begin
            errors++;
            $display("[TB] FAIL ghost_fv_count: got %0d expected 1", fv_count);
        end
        checks++;
        if (digits !== 16'h6709) begin
            errors++;
            $display("[TB] FAIL ghost_digits: got %h expected 6709", digits);
        end
        checks++;
        if (pattern_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ghost_err: got %b expected 0", pattern_err);
        end
    endtask

    task automatic test_clear_on_capture();
        int first;
        fv_count = 0;
        applyStimulus(4'b0001, pat(3), 16, first);
        applyStimulus(4'b0010, pat(3), 16, first);
        applyStimulus(4'b0100, pat(3), 16, first);
        // Step 9 after the change is the capture edge; raise clear just before it.
        applyStimulus(4'b1000, pat(3), 8, first);
        clear = 1'b1;
        applyStimulus(4'b1000, pat(3), 1, first);
        clear = 1'b0;
        applyStimulus(4'b1000, pat(3), 10, first);
        checks++;
        if (fv_count !== 0 || digits !== 16'h6709) begin
            errors++;
            $display("[TB] FAIL clear_capture: got %h (pulses %0d) expected 6709 (pulses 0)",
                     digits, fv_count);
        end
        // An empty mask means slot 3 alone cannot finish a frame.
        idle(4);
        applyStimulus(4'b1000, pat(5), 16, first);
        idle(4);
        checks++;
        if (fv_count !== 0) begin
            errors++;
            $display("[TB] FAIL clear_mask_empty: got %0d pulses expected 0", fv_count);
        end
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001 << i, pat(2 * (i + 1)), 16, first);
        end
        idle(4);
        checks++;
        if (fv_count !== 1 || digits !== 16'h8642) begin
            errors++;
            $display("[TB] FAIL clear_next_scan: got %h (pulses %0d) expected 8642 (pulses 1)",
                     digits, fv_count);
        end
    endtask

    task automatic test_reset_mid_scan();
        int first;
        fv_count = 0;
        applyStimulus(4'b0001, pat(7), 16, first);
        applyStimulus(4'b0010, pat(7), 16, first);
        an  = 4'b0000;
        seg = 7'b0000000;
        rst = 1'b1;
        #1;
        checks++;
        if (digits !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL rst_mid_digits: got %h expected ffff", digits);
        end
        checks++;
        if (frame_valid !== 1'b0 || pattern_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_flags: got fv=%b err=%b expected 0 0",
                     frame_valid, pattern_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        applyStimulus(4'b0001, pat(1), 16, first);
        applyStimulus(4'b0010, pat(2), 16, first);
        applyStimulus(4'b0100, pat(3), 16, first);
        checks++;
        if (fv_count !== 0) begin
            errors++;
            $display("[TB] FAIL rst_partial_fv: got %0d pulses expected 0", fv_count);
        end
        applyStimulus(4'b1000, pat(9), 16, first);
        checks++;
        if (first !== 9) begin
            errors++;
            $display("[TB] FAIL rst_final_latency: got step %0d expected 9", first);
        end
        idle(4);
        checks++;
        if (fv_count !== 1 || digits !== 16'h9321) begin
            errors++;
            $display("[TB] FAIL rst_new_frame: got %h (pulses %0d) expected 9321 (pulses 1)",
                     digits, fv_count);
        end
    endtask

    // Scenario sequence
    initial begin
        checks   = 0;
        errors   = 0;
        fv_count = 0;
        rst      = 1'b0;
        clear    = 1'b0;
        seg      = 7'b0;
        an       = 4'b0;
        test_reset();
        test_basic_scan();
        test_short_hold();
        test_bad_pattern();
        test_ghosting();
        test_clear_on_capture();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
